digit_serial_adder: RTL
=======================

# digit_serial_adder

Parametrised multi-cycle adder/subtractor that processes `DIGIT` bits per clock through a `DIGIT`-wide ripple of full adders. It carries between digits in a register and produces a `WIDTH`-bit result plus carry, signed-overflow and zero flags. It sits in the arithmetics library as the area-lean successor to the single-bit full adder. Operands arrive and results leave over valid/ready handshakes.

## Interface
- `WIDTH`, 16: operand and result width; must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits processed per cycle; `1 <= DIGIT <= WIDTH`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operand bundle valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: operand A, unsigned or two's complement.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in for add, borrow-in for subtract.
- `sub` input 1: 0 = add, 1 = subtract.
- `out_valid` output 1: result bundle valid.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: result.
- `cout` output 1: carry-out; for subtract, 1 = no borrow.
- `ovf` output 1: signed two's-complement overflow.
- `zero` output 1: `sum == 0`.

## Operation
- `NDIG = WIDTH/DIGIT`. The FSM has three states: IDLE, RUN, DONE.
- **IDLE:** `in_ready = 1`.
  - On `in_valid && in_ready`, latch `a`.
  - Latch `b_eff = sub ? ~b : b`.
  - Set carry register `c = sub ? ~cin : cin`, so subtract computes `a - b - cin`.
  - Clear the digit counter `k` and go to RUN.
- **RUN:** each cycle, add digit `k` of `a` and `b_eff` with `c`.
  - Write the digit result into `sum[k*DIGIT +: DIGIT]` and register the digit carry into `c`.
  - Increment `k`.
  - After digit `NDIG-1` is processed, go to DONE.
  - `in_ready = 0`.
- **DONE:** `out_valid = 1`.
  - `cout = c`.
  - `ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB])`.
  - `zero = ~|sum`.
  - On `out_valid && out_ready`, return to IDLE.
  - Outputs hold stable while `out_ready = 0`.
- Inputs are ignored outside IDLE. There is no pipelining and only one operation is in flight.
- `WIDTH == DIGIT` degenerates to a one-cycle RUN and is legal.
- Arithmetic is modulo 2^WIDTH. Bits above `WIDTH` are never stored.

## Timing
- **Reset (async, `rst_n = 0`):**
  - State goes to IDLE.
  - `in_ready = 1`, `out_valid = 0`.
  - `sum = 0`, `cout = 0`, `ovf = 0`.
  - `zero = 1`, since it is derived from `sum`.
  - `k = 0`, `c = 0`.
- **Reset mid-RUN or mid-DONE:** the operation is dropped with no output. The first `in_valid` after `rst_n` rises is accepted normally.
- **Latency:** operands accepted on edge T; `out_valid` goes high after edge T+NDIG.
- **Throughput:** at best one result per NDIG+2 cycles (accept, NDIG RUN cycles, DONE handshake, IDLE).
- `in_ready` and `out_valid` are registered state decodes with no combinational path from `in_valid` or `out_ready`.
- `sum` bits change only on RUN edges. Flags are valid exactly while `out_valid = 1`.

## Structure
- Shared package `arith_pkg`:
  - state encodings `ST_IDLE = 2'd0`, `ST_RUN = 2'd1`, `ST_DONE = 2'd2`;
  - parameter-check macro/function for `WIDTH % DIGIT == 0`.
- Sub-module `digit_ripple_adder #(DIGIT)`: purely combinational chain of `FullAdder` instances. Ports: `x`, `y` (DIGIT), `ci`; outputs `s` (DIGIT), `co`.
- Top-level: FSM, counter of width `$clog2(NDIG+1)`, operand/result registers, flag logic.

## Test plan
- WIDTH=16, DIGIT=4, add `a=0x1234`, `b=0x4321`, `cin=0` -> `sum=0x5555`, `cout=0`, `ovf=0`, `zero=0`, with `out_valid` exactly 4 cycles after acceptance.
- Add `a=0xFFFF`, `b=0x0001`, `cin=0` -> `sum=0x0000`, `cout=1`, `zero=1`, `ovf=0`. Same with `cin=1` -> `sum=0x0001`, `cout=1`.
- Subtract `a=0x8000`, `b=0x0001`, `cin=0` -> `sum=0x7FFF`, `cout=1`, `ovf=1`. Subtract `a=0x0003`, `b=0x0005`, `cin=1` -> `sum=0xFFFD`, `cout=0`.
- Hold `out_ready=0` for 5 cycles in DONE while toggling `in_valid`/`a` -> `in_ready=0`, result and flags unchanged. Release -> IDLE next cycle, and the new operand is accepted.
- Assert `rst_n=0` during the 2nd RUN cycle -> `out_valid=0`, `in_ready=1`, `sum=0` immediately (async). Then add `0x0F0F+0x00F1` -> `0x1000`.
- WIDTH=DIGIT=1, all 8 `{a,b,cin}` combinations with `sub=0` -> `{cout,sum}` equals `a+b+cin`, each after 1 RUN cycle. Repeat at WIDTH=8, DIGIT=8 and DIGIT=1 with random operands against a reference model.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg
//   Shared definitions for the arithmetic library: FSM state encodings and
//   an elaboration-time check on the digit-serial width/digit pairing.
//   No ports.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operand width must split into a whole number of non-empty digits.
  function automatic bit digit_cfg_ok(int width, int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/FullAdder.sv
// FullAdder
//   One-bit full adder, the leaf cell of the digit ripple chain.
//   Ports: a, b, ci (inputs) -> s (sum), co (carry-out).
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/digit_ripple_adder.sv
// digit_ripple_adder
//   Purely combinational DIGIT-bit ripple-carry adder built from FullAdder
//   cells; one digit of the serial datapath.
//   Ports: x, y (DIGIT-bit operands), ci (carry-in)
//          -> s (DIGIT-bit sum), co (carry-out of the top bit).
module digit_ripple_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    FullAdder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor that walks WIDTH-bit operands DIGIT bits
//   per clock through one digit_ripple_adder, carrying between digits in a
//   register. Operands in and results out over valid/ready handshakes; one
//   operation in flight at a time.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | in_ready=1, waiting for an operand bundle
//   RUN     | one digit per cycle, k = digit index, c = inter-digit carry
//   DONE    | out_valid=1, result and flags held until out_ready
//
//   Ports: clk, rst_n (async, active-low)
//          in_valid/in_ready, a, b, cin, sub   : operand side
//          out_valid/out_ready, sum, cout, ovf, zero : result side
module digit_serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = $clog2(NDIG + 1);
  localparam int MSB  = WIDTH - 1;
  localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT{1'b1}});

  if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
  end

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtract
  logic             c_q;
  logic [WIDTH-1:0] sum_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [31:0]      base_d;
  logic [DIGIT-1:0] dig_a_d;
  logic [DIGIT-1:0] dig_b_d;
  logic [DIGIT-1:0] dig_s_d;
  logic             dig_co_d;
  logic [WIDTH-1:0] sum_d;
  logic             last_dig_d;

  // Digit selection by shifting keeps the index arithmetic width-clean for
  // every WIDTH/DIGIT pairing, including the single-digit case.
  assign base_d  = 32'(k_q) * 32'(DIGIT);
  assign dig_a_d = DIGIT'(a_q >> base_d);
  assign dig_b_d = DIGIT'(b_q >> base_d);
  assign sum_d   = (sum_q & ~(DIG_MASK << base_d)) | (WIDTH'(dig_s_d) << base_d);
  assign last_dig_d = (k_q == KW'(NDIG - 1));

  digit_ripple_adder #(
    .DIGIT (DIGIT)
  ) u_ripple (
    .x  (dig_a_d),
    .y  (dig_b_d),
    .ci (c_q),
    .s  (dig_s_d),
    .co (dig_co_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            // Inverted borrow-in as carry-in: a + ~b + ~cin = a - b - cin.
            c_q        <= sub ? ~cin : cin;
            k_q        <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_q <= sum_d;
          c_q   <= dig_co_d;
          k_q   <= k_q + KW'(1);
          if (last_dig_d) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = c_q;
  assign ovf       = (a_q[MSB] == b_q[MSB]) && (sum_q[MSB] != a_q[MSB]);
  assign zero      = ~|sum_q;

endmodule
